// File: rtl/alu_host_pkg.sv
// Shared definitions for the ALU requester-side sequencer.
package alu_host_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_LOAD_A   = 6'b000010,
        ST_LOAD_B   = 6'b000100,
        ST_WAIT_END = 6'b001000,
        ST_BEAT2    = 6'b010000,
        ST_RESP     = 6'b100000
    } state_e;

    // MUL and DIV return a second result byte on the cycle after END.
    function automatic logic two_beat(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_host_timer.sv
// WAIT_END watchdog: free-running counter with clear/enable and a terminal-count flag.
module alu_host_timer
    import alu_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_host_seq.sv
// Drives the ALU BEGIN/op_code/inbus pins for one request, collects the
// 1- or 2-byte result after END and returns it over a valid/ready port.
module alu_host_seq
    import alu_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned DW             = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic          alu_begin,
    output logic [1:0]    alu_op_code,
    output logic [DW-1:0] alu_inbus,
    input  logic [DW-1:0] alu_outbus,
    input  logic          alu_end,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_lo,
    output logic [DW-1:0] rsp_hi,
    output logic          rsp_err,
    output logic          busy
);

    state_e        state_q;
    logic [1:0]    op_q;
    logic [DW-1:0] b_q;
    logic          req_ready_q;
    logic          busy_q;
    logic          alu_begin_q;
    logic [1:0]    alu_op_code_q;
    logic [DW-1:0] alu_inbus_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_lo_q;
    logic [DW-1:0] rsp_hi_q;
    logic          rsp_err_q;
    logic          tc;

    alu_host_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_ni(reset),
        .clr_i (state_q == ST_LOAD_B),
        .en_i  (state_q == ST_WAIT_END),
        .tc_o  (tc)
    );

    // Outputs are registered: each state's pin values are loaded on the edge that enters it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            b_q           <= '0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            alu_begin_q   <= 1'b0;
            alu_op_code_q <= '0;
            alu_inbus_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_lo_q      <= '0;
            rsp_hi_q      <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q          <= req_op;
                        b_q           <= req_b;
                        req_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        alu_begin_q   <= 1'b1;
                        alu_op_code_q <= req_op;
                        alu_inbus_q   <= req_a;
                        state_q       <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    alu_begin_q <= 1'b0;
                    alu_inbus_q <= b_q;
                    state_q     <= ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    alu_inbus_q <= '0;
                    state_q     <= ST_WAIT_END;
                end
                ST_WAIT_END: begin
                    // END takes priority over a timeout on the same edge.
                    if (alu_end) begin
                        rsp_lo_q  <= alu_outbus;
                        rsp_err_q <= 1'b0;
                        if (two_beat(op_q)) begin
                            state_q <= ST_BEAT2;
                        end else begin
                            rsp_hi_q      <= '0;
                            rsp_valid_q   <= 1'b1;
                            alu_op_code_q <= '0;
                            state_q       <= ST_RESP;
                        end
                    end else if (tc) begin
                        rsp_lo_q      <= '0;
                        rsp_hi_q      <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        alu_op_code_q <= '0;
                        state_q       <= ST_RESP;
                    end
                end
                ST_BEAT2: begin
                    rsp_hi_q      <= alu_outbus;
                    rsp_valid_q   <= 1'b1;
                    alu_op_code_q <= '0;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    req_ready_q   <= 1'b1;
                    busy_q        <= 1'b0;
                    alu_begin_q   <= 1'b0;
                    alu_op_code_q <= '0;
                    alu_inbus_q   <= '0;
                    rsp_valid_q   <= 1'b0;
                    rsp_err_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign alu_begin   = alu_begin_q;
    assign alu_op_code = alu_op_code_q;
    assign alu_inbus   = alu_inbus_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_lo      = rsp_lo_q;
    assign rsp_hi      = rsp_hi_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: doc/alu_host_seq.md
Name: alu_host_seq

Overview:
Requester-side sequencer for the ALU's BEGIN/op_code/inbus/outbus/END protocol. It takes one operation request (op, A, B) over a valid/ready port and drives the ALU pins cycle-accurately. It then waits for END, collects the 1- or 2-byte result and returns it over a valid/ready response port. It replaces hand-written stimulus and lets a host block issue ALU operations back-to-back.

Parameters:
TIMEOUT_CYCLES, 64, maximum number of WAIT_END cycles before the operation is aborted with an error.
DW, 8, width of the operand and result byte; fixed to the ALU bus width.

Ports:
clk  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
req_a  in  DW  first operand
req_b  in  DW  second operand
alu_begin  out  1  drives ALU BEGIN
alu_op_code  out  2  drives ALU op_code
alu_inbus  out  DW  drives ALU inbus
alu_outbus  in  DW  ALU result bus
alu_end  in  1  ALU END
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_lo  out  DW  result beat 0 (ADD/SUB result, MUL low byte, DIV quotient)
rsp_hi  out  DW  result beat 1 (MUL high byte, DIV remainder; 0 for ADD/SUB)
rsp_err  out  1  timeout flag
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs are 0 except req_ready=1. Request/result registers are cleared. Reset asserted mid-operation aborts the operation immediately and produces no response.
- States: IDLE, LOAD_A, LOAD_B, WAIT_END, BEAT2, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op/A/B and go to LOAD_A.
- LOAD_A (1 cycle):
  - alu_begin=1, alu_op_code=op, alu_inbus=A.
  - Go to LOAD_B.
- LOAD_B (1 cycle):
  - alu_begin=0, alu_inbus=B.
  - Clear the timeout counter; go to WAIT_END.
- WAIT_END:
  - alu_inbus=0; counter increments each cycle.
  - alu_end=1 (sampled at the clock edge): capture alu_outbus into rsp_lo. Go to BEAT2 if op is MUL or DIV, else go to RESP with rsp_hi=0.
  - Counter reaches TIMEOUT_CYCLES-1 with alu_end=0: go to RESP with rsp_err=1 and rsp_lo=rsp_hi=0.
  - alu_end and the timeout in the same cycle: alu_end wins and err=0.
- BEAT2 (1 cycle): capture alu_outbus into rsp_hi; go to RESP. alu_end is not rechecked.
- RESP:
  - rsp_valid=1; rsp_lo/hi/err held stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE and clear rsp_err. rsp_valid falls the next cycle.
- alu_op_code stays at the latched op from LOAD_A through BEAT2 and is 0 in IDLE/RESP.
- alu_end is ignored in IDLE, LOAD_A, LOAD_B and RESP.
- Latency:
  - Request accepted at edge N gives alu_begin high during cycle N+1.
  - END sampled at edge M gives rsp_valid at M+1 for 1-beat ops and M+2 for 2-beat ops.
  - Minimum accept-to-accept interval is 5 cycles.
- No arithmetic is performed in this block; bytes are passed through unmodified.

Decomposition:
- Package alu_host_pkg:
  - op-code constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - state encoding (one-hot, 6 bits);
  - function two_beat(op) returning 1 for MUL/DIV.
- Sub-module alu_host_timer: counter with clear and enable, asynchronous active-low reset, terminal-count output at TIMEOUT_CYCLES-1.
- The FSM and datapath registers stay in alu_host_seq.

Test Plan:
- ADD 127+0, BFM ALU asserts END 3 cycles after LOAD_B, outbus=127 -> pins show begin=1/inbus=127, then begin=0/inbus=0 on consecutive cycles; rsp_lo=127, rsp_hi=0, rsp_err=0.
- MUL 200*200, BFM drives 0x40 then 0x9C on consecutive cycles from END -> rsp_lo=0x40, rsp_hi=0x9C, err=0; MUL 7*3 -> rsp_lo=21, rsp_hi=0.
- BFM never asserts END -> rsp_valid exactly 64 cycles after entering WAIT_END; rsp_err=1, rsp_lo=rsp_hi=0; next request is accepted normally.
- rsp_ready held 0 for 5 cycles -> rsp_valid and data stable; req_ready=0 throughout; back-to-back second request is accepted the cycle after the handshake.
- Spurious alu_end=1 during LOAD_A, plus END coinciding with the timeout edge -> first is ignored; second yields err=0 with the captured data.
- reset driven low mid-WAIT_END, between clock edges -> alu_begin=0, busy=0 and req_ready=1 immediately; no rsp_valid after release.
